mux_scan: RTL and testbench

Parametrised, pipelined N:1 data multiplexer with manual select and automatic channel-scan modes. Selection is a two-level tree (4:1 slices, then a group-level mux) with a register after each level. A channel pointer either holds a loaded value or advances round-robin every DWELL enabled cycles. It sits between the lab input banks and any single-channel consumer, such as the display or serial logger.

---
 rtl/mux_scan_pkg.sv | 42 ++++
 rtl/mux_scan_mux4_slice.sv | 20 ++
 rtl/mux_scan.sv | 140 ++++++++++++++
 tb/tb_mux_scan.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux_scan channel multiplexer.
// Optional feature macro: MUX_SCAN_MASK_EN (scan skips channels whose mask bit is 0).
package mux_scan_pkg;

  typedef enum logic [0:0] {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Largest supported channel count; the search helper works on this width.
  localparam int MAX_CH = 64;

  typedef struct packed {
    logic       found;
    logic [5:0] idx;
  } next_ch_t;

  // Next channel after cur (circular, cur itself last) whose mask bit is set.
  // Steps are walked from far to near so the nearest hit is the one kept.
  function automatic next_ch_t next_enabled_ch(input logic [5:0]        cur,
                                               input logic [MAX_CH-1:0] mask,
                                               input int                n_ch);
    next_ch_t r;
    int       c;
    r.found = 1'b0;
    r.idx   = cur;
    for (int step = MAX_CH; step >= 1; step--) begin
      if (step <= n_ch) begin
        c = (int'(cur) + step) % n_ch;
        if (mask[6'(c)]) begin
          r.found = 1'b1;
          r.idx   = 6'(c);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_mux4_slice.sv
// W-bit 4:1 combinational mux; one instance per group of four channels.
module mux4_slice #(
  parameter int W = 8
) (
  input  logic [4*W-1:0] d_i,
  input  logic [1:0]     sel_i,
  output logic [W-1:0]   y_o
);

  always_comb begin
    y_o = d_i[W-1:0];
    case (sel_i)
      2'd0:    y_o = d_i[0*W +: W];
      2'd1:    y_o = d_i[1*W +: W];
      2'd2:    y_o = d_i[2*W +: W];
      default: y_o = d_i[3*W +: W];
    endcase
  end

endmodule

// File: rtl/mux_scan.sv
// Pipelined N:1 channel mux with manual select and round-robin scan modes.
// Optional feature macro: MUX_SCAN_MASK_EN adds ch_mask to restrict scanned channels.
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter  int N_CH  = 16,
  parameter  int W     = 8,
  parameter  int DWELL = 4,
  localparam int CW    = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic [CW-1:0]     sel,
  input  logic              sel_load,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N_CH-1:0]   ch_mask,
`endif
  input  logic [N_CH*W-1:0] data_in,
  output logic [W-1:0]      data_out,
  output logic [CW-1:0]     ch_out,
  output logic              valid,
  output logic              wrap
);

  localparam int NG  = N_CH / 4;
  localparam int GW  = (NG > 1) ? $clog2(NG) : 1;
  localparam int DCW = $clog2(DWELL + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   ptr_q, ptr_d;
  logic [DCW-1:0]  dwell_q, dwell_d;
  logic            wrap_q, wrap_d;

  logic [W-1:0]    slice_y   [NG];
  logic [W-1:0]    s1_data_q [NG];
  logic [CW-1:0]   s1_ptr_q;
  logic            s1_vld_q;

  logic [W-1:0]    data_q;
  logic [CW-1:0]   ch_q;
  logic            valid_q;

  logic [GW-1:0]   grp;
  logic [MAX_CH-1:0] scan_mask;
  next_ch_t        nxt;
  logic            sel_ok;

  always_comb begin
    scan_mask = '0;
`ifdef MUX_SCAN_MASK_EN
    scan_mask[N_CH-1:0] = ch_mask;
`else
    scan_mask[N_CH-1:0] = '1;
`endif
  end

  assign nxt    = next_enabled_ch(6'(ptr_q), scan_mask, N_CH);
  assign sel_ok = (int'(sel) < N_CH);

  // Load beats mode change beats scan advance; an out-of-range sel is as if absent.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    if (en) begin
      state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
      if (sel_load && sel_ok) begin
        ptr_d   = sel;
        dwell_d = '0;
      end else if (state_d != state_q) begin
        dwell_d = '0;
      end else if (state_q == ST_SCAN) begin
        if (dwell_q == DCW'(DWELL - 1)) begin
          dwell_d = '0;
          if (nxt.found) begin
            ptr_d  = CW'(nxt.idx);
            wrap_d = (CW'(nxt.idx) <= ptr_q);
          end
        end else begin
          dwell_d = dwell_q + DCW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_MANUAL;
      ptr_q   <= '0;
      dwell_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
      wrap_q  <= wrap_d;
    end
  end

  for (genvar g = 0; g < NG; g++) begin : g_slice
    mux4_slice #(.W(W)) u_slice (
      .d_i   (data_in[g*4*W +: 4*W]),
      .sel_i (ptr_q[1:0]),
      .y_o   (slice_y[g])
    );
  end

  if (NG > 1) begin : g_grp
    assign grp = s1_ptr_q[CW-1:2];
  end else begin : g_grp1
    assign grp = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < NG; g++) s1_data_q[g] <= '0;
      s1_ptr_q <= '0;
      s1_vld_q <= 1'b0;
      data_q   <= '0;
      ch_q     <= '0;
      valid_q  <= 1'b0;
    end else if (en) begin
      for (int g = 0; g < NG; g++) s1_data_q[g] <= slice_y[g];
      s1_ptr_q <= ptr_q;
      s1_vld_q <= 1'b1;
      data_q   <= s1_data_q[grp];
      ch_q     <= s1_ptr_q;
      valid_q  <= s1_vld_q;
    end
  end

  assign data_out = data_q;
  assign ch_out   = ch_q;
  assign valid    = valid_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_mux_scan.sv
// Randomised scoreboard bench for mux_scan (N_CH=16, W=8, DWELL=3).
module tb_mux_scan;

  localparam int N_CH  = 16;
  localparam int W     = 8;
  localparam int DWELL = 3;
  localparam int CW    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              mode = 1'b0;
  logic [CW-1:0]     sel = '0;
  logic              sel_load = 1'b0;
  logic [N_CH*W-1:0] data_in = '0;
  logic [W-1:0]      data_out;
  logic [CW-1:0]     ch_out;
  logic              valid;
  logic              wrap;
  logic [N_CH-1:0]   tb_mask = '1;
`ifdef MUX_SCAN_MASK_EN
  logic [N_CH-1:0]   ch_mask = '1;
`endif

  mux_scan #(.N_CH(N_CH), .W(W), .DWELL(DWELL)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .sel      (sel),
    .sel_load (sel_load),
`ifdef MUX_SCAN_MASK_EN
    .ch_mask  (ch_mask),
`endif
    .data_in  (data_in),
    .data_out (data_out),
    .ch_out   (ch_out),
    .valid    (valid),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [CW+W-1:0] exp_q[$];

  int              m_ptr = 0, m_dwell = 0, m_state = 0, en_cnt = 0;
  logic            exp_wrap = 1'b0, exp_valid = 1'b0, cur_en = 1'b0, mon_on = 1'b0;
  logic            have_last = 1'b0;
  logic [CW+W-1:0] last_e = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference pointer walk: next channel in circular order with mask bit set, -1 if none.
  function automatic int model_next(input int p);
    int c;
    for (int s = 1; s <= N_CH; s++) begin
      c = (p + s) % N_CH;
      if (tb_mask[CW'(c)]) return c;
    end
    return -1;
  endfunction

  // Drive one cycle of inputs and predict the DUT's response to the coming edge.
  task automatic step(input logic e, input logic m, input logic ld, input int s, input bit pattern);
    int nx;
    @(negedge clk);
    en = e; mode = m; sel_load = ld; sel = CW'(s);
`ifdef MUX_SCAN_MASK_EN
    ch_mask = tb_mask;
`endif
    for (int c = 0; c < N_CH; c++)
      data_in[c*W +: W] = pattern ? W'(8'h10 + c) : W'($urandom_range(0, 255));
    cur_en   = e;
    exp_wrap = 1'b0;
    if (e) begin
      exp_q.push_back({CW'(m_ptr), data_in[m_ptr*W +: W]});
      en_cnt++;
      if (ld && s < N_CH) begin
        m_ptr = s; m_dwell = 0;
      end else if (int'(m) != m_state) begin
        m_dwell = 0;
      end else if (m_state == 1) begin
        if (m_dwell == DWELL - 1) begin
          m_dwell = 0;
          nx = model_next(m_ptr);
          if (nx >= 0) begin
            exp_wrap = (nx <= m_ptr);
            m_ptr    = nx;
          end
        end else begin
          m_dwell++;
        end
      end
      m_state = int'(m);
    end
    exp_valid = (en_cnt >= 2);
  endtask

  task automatic model_clear();
    m_ptr = 0; m_dwell = 0; m_state = 0; en_cnt = 0;
    exp_q.delete();
    have_last = 1'b0; exp_wrap = 1'b0; exp_valid = 1'b0; cur_en = 1'b0;
    en = 1'b0; mode = 1'b0; sel_load = 1'b0;
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_ch_out", 32'(ch_out), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    @(negedge clk);
    @(negedge clk);
    model_clear();
    rst = 1'b0;
  endtask

  // Monitor: compares every edge's outputs against the scoreboard.
  initial begin
    logic [CW+W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on && !rst) begin
        check("wrap", 32'(wrap), 32'(exp_wrap));
        check("valid", 32'(valid), 32'(exp_valid));
        if (cur_en) begin
          if (valid) begin
            if (exp_q.size() == 0) begin
              check("queue_nonempty", 32'h0, 32'h1);
            end else begin
              e = exp_q.pop_front();
              check("ch_out", 32'(ch_out), 32'(e[CW+W-1:W]));
              check("data_out", 32'(data_out), 32'(e[W-1:0]));
              last_e    = e;
              have_last = 1'b1;
            end
          end
        end else if (have_last) begin
          check("hold_ch_out", 32'(ch_out), 32'(last_e[CW+W-1:W]));
          check("hold_data_out", 32'(data_out), 32'(last_e[W-1:0]));
        end
      end
    end
  end

  initial begin
    int  guard;
    logic rm;
    rst = 1'b1;
    #12;
    check("init_data_out", 32'(data_out), 32'h0);
    check("init_ch_out", 32'(ch_out), 32'h0);
    check("init_valid", 32'(valid), 32'h0);
    @(negedge clk);
    model_clear();
    rst    = 1'b0;
    mon_on = 1'b1;

    // Manual select of channel 9 with a recognisable data pattern.
    repeat (2) step(1, 0, 0, 0, 1);
    step(1, 0, 1, 9, 1);
    repeat (4) step(1, 0, 0, 0, 1);
    @(posedge clk);
    #2;
    check("manual_ch9", 32'(ch_out), 32'd9);
    check("manual_data19", 32'(data_out), 32'h19);

    // Scan from channel 14 across the top, wrapping to 0.
    step(1, 0, 1, 14, 0);
    step(1, 1, 0, 0, 0);
    repeat (12) step(1, 1, 0, 0, 0);

    // Load coinciding with a scheduled advance.
    guard = 0;
    while (m_dwell != DWELL - 1 && guard < 10) begin
      step(1, 1, 0, 0, 0);
      guard++;
    end
    check("advance_reached", 32'(m_dwell), 32'(DWELL - 1));
    step(1, 1, 1, 5, 0);
    repeat (6) step(1, 1, 0, 0, 0);

    // Freeze mid-dwell, then resume.
    step(1, 1, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0, 0);
    repeat (8) step(1, 1, 0, 0, 0);

    // Asynchronous reset mid-scan, then recover in MANUAL.
    reset_mid();
    repeat (4) step(1, 0, 0, 0, 0);

    // Randomised traffic.
    rm = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) rm = ~rm;
      step(($urandom_range(0, 9) != 0), rm, ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, N_CH - 1)), 0);
    end

`ifdef MUX_SCAN_MASK_EN
    tb_mask = 16'h8421;
    step(1, 1, 1, 0, 0);
    repeat (16) step(1, 1, 0, 0, 0);
    tb_mask = '0;
    repeat (10) step(1, 1, 0, 0, 0);
    tb_mask = 16'h0010;
    repeat (10) step(1, 1, 0, 0, 0);
    tb_mask = '1;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 9) == 0) tb_mask = N_CH'($urandom);
      step(($urandom_range(0, 7) != 0), 1'b1, ($urandom_range(0, 15) == 0),
           int'($urandom_range(0, N_CH - 1)), 0);
    end
`endif

    repeat (3) step(1, 1, 0, 0, 0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
